// File: rtl/ucode_seq_if.sv
// Bus between the IR/microcode ROM and the microcode sequencer.
// With UCODE_SEQ_IRQ_EN defined, the irq/irq_ack/irq_active signals are added.
interface ucode_seq_if #(
  parameter int unsigned OPCODE_W = 8,
  parameter int unsigned TSTATE_W = 3,
  parameter int unsigned UINSTR_W = 16
);
  logic [OPCODE_W-1:0]          opcode;
  logic [UINSTR_W-1:0]          uinstr_in;
  logic                         wait_req;
  logic [OPCODE_W+TSTATE_W-1:0] uaddr;
  logic [UINSTR_W-1:0]          uinstr_out;
  logic [TSTATE_W-1:0]          T;
  logic                         instr_start;
  logic                         retired;
  logic                         overrun;
`ifdef UCODE_SEQ_IRQ_EN
  logic                         irq;
  logic                         irq_ack;
  logic                         irq_active;
`endif

  modport master (
    input  opcode, uinstr_in, wait_req,
`ifdef UCODE_SEQ_IRQ_EN
    input  irq,
    output irq_ack, irq_active,
`endif
    output uaddr, uinstr_out, T, instr_start, retired, overrun
  );

  modport slave (
    output opcode, uinstr_in, wait_req,
`ifdef UCODE_SEQ_IRQ_EN
    output irq,
    input  irq_ack, irq_active,
`endif
    input  uaddr, uinstr_out, T, instr_start, retired, overrun
  );
endinterface

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: steps T per instruction, forms ROM address {opcode_eff, T},
// ends on RT or at MAX_T, and freezes on wait_req. Optional IRQ entry: UCODE_SEQ_IRQ_EN.
module ucode_sequencer #(
  parameter int unsigned          OPCODE_W    = 8,
  parameter int unsigned          TSTATE_W    = 3,
  parameter int unsigned          UINSTR_W    = 16,
  parameter int unsigned          MAX_T       = 7,
  parameter int unsigned          RT_BIT      = 7,
  parameter logic [UINSTR_W-1:0]  STROBE_MASK = 16'h0F00
`ifdef UCODE_SEQ_IRQ_EN
  ,
  parameter logic [OPCODE_W-1:0]  IRQ_OPCODE  = 8'hFF
`endif
) (
  input  logic     clk,
  input  logic     RST,
  ucode_seq_if.master bus
);

  // Bits cleared while stalled: bus input strobes plus the RT bit.
  localparam logic [UINSTR_W-1:0] STALL_MASK = STROBE_MASK | (UINSTR_W'(1) << RT_BIT);

  logic [TSTATE_W-1:0] t_q;
  logic                retired_q;
  logic                overrun_q;
  logic [OPCODE_W-1:0] opcode_eff;
  logic                rt_hit;
  logic                at_max;
  logic                instr_end;

  assign rt_hit    = bus.uinstr_in[RT_BIT];
  assign at_max    = (t_q == TSTATE_W'(MAX_T));
  assign instr_end = ~bus.wait_req & (rt_hit | at_max);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      t_q       <= '0;
      retired_q <= 1'b0;
      overrun_q <= 1'b0;
    end else if (bus.wait_req) begin
      retired_q <= 1'b0;
    end else if (rt_hit) begin
      t_q       <= '0;
      retired_q <= 1'b1;
    end else if (at_max) begin
      t_q       <= '0;
      retired_q <= 1'b1;
      overrun_q <= 1'b1;
    end else begin
      t_q       <= t_q + TSTATE_W'(1);
      retired_q <= 1'b0;
    end
  end

`ifdef UCODE_SEQ_IRQ_EN
  logic irq_active_q;
  logic irq_ack_q;

  // IRQ is taken at an instruction boundary; the IRQ routine's own end releases it.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      irq_active_q <= 1'b0;
      irq_ack_q    <= 1'b0;
    end else begin
      irq_ack_q <= 1'b0;
      if (instr_end) begin
        if (irq_active_q) begin
          irq_active_q <= 1'b0;
        end else if (bus.irq) begin
          irq_active_q <= 1'b1;
          irq_ack_q    <= 1'b1;
        end
      end
    end
  end

  assign opcode_eff     = irq_active_q ? IRQ_OPCODE : bus.opcode;
  assign bus.irq_ack    = irq_ack_q;
  assign bus.irq_active = irq_active_q;
`else
  logic unused_end;
  assign unused_end = instr_end;
  assign opcode_eff = bus.opcode;
`endif

  assign bus.T           = t_q;
  assign bus.retired     = retired_q;
  assign bus.overrun     = overrun_q;
  assign bus.uaddr       = {opcode_eff, t_q};
  assign bus.instr_start = (t_q == '0) & ~RST;

  always_comb begin
    bus.uinstr_out = bus.uinstr_in;
    if (RST)               bus.uinstr_out = '0;
    else if (bus.wait_req) bus.uinstr_out = bus.uinstr_in & ~STALL_MASK;
  end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer: sequencing, stall masking, overrun, async reset, IRQ.
module tb_ucode_sequencer;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [7:0] eff_op;

  ucode_seq_if bus ();

  ucode_sequencer dut (
    .clk (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs, check combinational view, clock, check registered view.
  task automatic run_vec(input logic [15:0] uin, input logic w, input logic [2:0] et,
                         input logic [15:0] euo, input logic er, input logic eo);
    bus.uinstr_in = uin;
    bus.wait_req  = w;
    #1;
    check("T", 32'(bus.T), 32'(et));
    check("uaddr", 32'(bus.uaddr), 32'({eff_op, et}));
    check("uinstr_out", 32'(bus.uinstr_out), 32'(euo));
    check("instr_start", 32'(bus.instr_start), 32'(et == 3'd0));
    @(posedge clk);
    #1;
    check("retired", 32'(bus.retired), 32'(er));
    check("overrun", 32'(bus.overrun), 32'(eo));
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    bus.opcode    = 8'h12;
    eff_op        = 8'h12;
    bus.uinstr_in = 16'hFFFF;
    bus.wait_req  = 1'b0;
`ifdef UCODE_SEQ_IRQ_EN
    bus.irq = 1'b0;
`endif
    #1;
    check("rst_T", 32'(bus.T), 32'd0);
    check("rst_retired", 32'(bus.retired), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_uinstr_out", 32'(bus.uinstr_out), 32'd0);
    check("rst_instr_start", 32'(bus.instr_start), 32'd0);
`ifdef UCODE_SEQ_IRQ_EN
    check("rst_irq_ack", 32'(bus.irq_ack), 32'd0);
    check("rst_irq_active", 32'(bus.irq_active), 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic: opcode 12, RT at T=3
    run_vec(16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
    run_vec(16'h0000, 1'b0, 3'd1, 16'h0000, 1'b0, 1'b0);
    run_vec(16'h0000, 1'b0, 3'd2, 16'h0000, 1'b0, 1'b0);
    run_vec(16'h0080, 1'b0, 3'd3, 16'h0080, 1'b1, 1'b0);

    // Stall two cycles at T=1: six cycles total
    run_vec(16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
    run_vec(16'hFFFF, 1'b1, 3'd1, 16'hF07F, 1'b0, 1'b0);
    run_vec(16'hFFFF, 1'b1, 3'd1, 16'hF07F, 1'b0, 1'b0);
    run_vec(16'hFF7F, 1'b0, 3'd1, 16'hFF7F, 1'b0, 1'b0);
    run_vec(16'h0000, 1'b0, 3'd2, 16'h0000, 1'b0, 1'b0);
    run_vec(16'h0080, 1'b0, 3'd3, 16'h0080, 1'b1, 1'b0);

    // RT only at MAX_T, opcode change at T=4, stall at T=7 holds
    for (int i = 0; i < 4; i++) run_vec(16'h0000, 1'b0, 3'(i), 16'h0000, 1'b0, 1'b0);
    bus.opcode = 8'h56;
    eff_op     = 8'h56;
    for (int i = 4; i < 7; i++) run_vec(16'h0000, 1'b0, 3'(i), 16'h0000, 1'b0, 1'b0);
    run_vec(16'h0000, 1'b1, 3'd7, 16'h0000, 1'b0, 1'b0);
    run_vec(16'h0080, 1'b0, 3'd7, 16'h0080, 1'b1, 1'b0);

    // Overrun: no RT through T=7, then sticky across an RT-ended instruction
    bus.opcode = 8'h34;
    eff_op     = 8'h34;
    for (int i = 0; i < 7; i++) run_vec(16'h0001, 1'b0, 3'(i), 16'h0001, 1'b0, 1'b0);
    run_vec(16'h0001, 1'b0, 3'd7, 16'h0001, 1'b1, 1'b1);
    run_vec(16'h0080, 1'b0, 3'd0, 16'h0080, 1'b1, 1'b1);

    // Async reset at T=5, between edges
    for (int i = 0; i < 5; i++) run_vec(16'h0000, 1'b0, 3'(i), 16'h0000, 1'b0, 1'b1);
    bus.uinstr_in = 16'hFFFF;
    #1;
    check("pre_rst_T", 32'(bus.T), 32'd5);
    check("pre_rst_uinstr_out", 32'(bus.uinstr_out), 32'hFFFF);
    rst = 1'b1;
    #1;
    check("async_T", 32'(bus.T), 32'd0);
    check("async_uinstr_out", 32'(bus.uinstr_out), 32'd0);
    check("async_overrun", 32'(bus.overrun), 32'd0);
    check("async_instr_start", 32'(bus.instr_start), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
    run_vec(16'h0080, 1'b0, 3'd1, 16'h0080, 1'b1, 1'b0);

`ifdef UCODE_SEQ_IRQ_EN
    // IRQ taken at the end of an opcode 12 instruction
    bus.opcode = 8'h12;
    eff_op     = 8'h12;
    bus.irq    = 1'b1;
    run_vec(16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
    check("irq_ack_early", 32'(bus.irq_ack), 32'd0);
    run_vec(16'h0080, 1'b0, 3'd1, 16'h0080, 1'b1, 1'b0);
    check("irq_ack_pulse", 32'(bus.irq_ack), 32'd1);
    check("irq_active_set", 32'(bus.irq_active), 32'd1);
    bus.irq = 1'b0;
    eff_op  = 8'hFF;
    run_vec(16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
    check("irq_ack_once", 32'(bus.irq_ack), 32'd0);
    check("irq_active_hold", 32'(bus.irq_active), 32'd1);
    run_vec(16'h0080, 1'b0, 3'd1, 16'h0080, 1'b1, 1'b0);
    check("irq_active_clr", 32'(bus.irq_active), 32'd0);
    eff_op = 8'h12;
    run_vec(16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
